// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator.
// Holds the waveform-select encodings used by tone_gen and phase_acc.
package tone_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'd0,
    MODE_PULSE    = 2'd1,
    MODE_SAW      = 2'd2,
    MODE_TRIANGLE = 2'd3
  } tone_mode_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with double-buffered tone parameters.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - run the accumulator; when low phase is held at 0
//   load            - capture mode/fcw/duty/amp into the shadow set
//   mode/fcw/duty/amp - new tone parameters
//   phase           - current phase register
//   act_mode/act_duty/act_amp - parameters currently in force
//   wrap            - high in the cycle whose phase resulted from a carry
module phase_acc
  import tone_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] duty,
  input  logic [AMP_W-1:0]   amp,
  output logic [PHASE_W-1:0] phase,
  output logic [1:0]         act_mode,
  output logic [PHASE_W-1:0] act_duty,
  output logic [AMP_W-1:0]   act_amp,
  output logic               wrap
);

  typedef struct packed {
    tone_mode_e         mode;
    logic [PHASE_W-1:0] fcw;
    logic [PHASE_W-1:0] duty;
    logic [AMP_W-1:0]   amp;
  } cfg_t;

  cfg_t               cfg_in;
  cfg_t               shd_d, shd_q;
  cfg_t               act_d, act_q;
  logic [PHASE_W-1:0] phase_d, phase_q;
  logic               wrap_d, wrap_q;
  logic [PHASE_W:0]   sum;
  logic               carry;

  always_comb begin
    cfg_in = '{mode: tone_mode_e'(mode), fcw: fcw, duty: duty, amp: amp};
    sum    = {1'b0, phase_q} + {1'b0, act_q.fcw};
    carry  = sum[PHASE_W];
    shd_d  = load ? cfg_in : shd_q;
    // Active set only changes at a period boundary (or while idle), so a
    // new mode/fcw never cuts a period short. Taking shd_d rather than
    // shd_q lets a load in the wrap cycle take effect immediately.
    act_d   = (!en || carry) ? shd_d : act_q;
    phase_d = en ? sum[PHASE_W-1:0] : '0;
    wrap_d  = en & carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_q   <= '0;
      act_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      shd_q   <= shd_d;
      act_q   <= act_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign phase    = phase_q;
  assign act_mode = act_q.mode;
  assign act_duty = act_q.duty;
  assign act_amp  = act_q.amp;
  assign wrap     = wrap_q;

endmodule

// File: rtl/tone_gen.sv
// Numerically controlled tone generator: square, pulse, saw and triangle.
// PHASE_W must be at least OUT_W+1.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - generator enable; low forces phase and outputs to 0
//   load      - capture mode/fcw/duty/amp (applied at the next wrap)
//   mode      - waveform select (tone_pkg encodings)
//   fcw       - unsigned phase increment per cycle
//   duty      - unsigned pulse threshold on the phase
//   amp       - unsigned amplitude, full scale = 2^(OUT_W-1)
//   tone      - signed output sample, 2 cycles behind the phase register
//   wrap      - one-cycle strobe aligned with the first sample of a period
module tone_gen
  import tone_pkg::*;
#(
  parameter int OUT_W   = 24,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] duty,
  input  logic [OUT_W-2:0]   amp,
  output logic [OUT_W-1:0]   tone,
  output logic               wrap
);

  localparam logic signed [OUT_W-1:0] FS     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] FS_NEG = -FS;
  localparam logic signed [OUT_W-1:0] MIN_V  = {1'b1, {(OUT_W-1){1'b0}}};

  // Keep the waveform symmetric: the one extra negative code is folded in.
  function automatic logic signed [OUT_W-1:0] sat_sym(input logic signed [OUT_W-1:0] x);
    return (x == MIN_V) ? FS_NEG : x;
  endfunction

  // Floor-scaled amplitude multiply; |raw| <= FS and amp < 2^(OUT_W-1)
  // keep the result inside OUT_W bits.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] s,
                                                    input logic [OUT_W-2:0] a);
    logic signed [2*OUT_W-1:0] se;
    logic signed [2*OUT_W-1:0] ae;
    logic signed [2*OUT_W-1:0] prod;
    se   = (2*OUT_W)'(s);
    ae   = (2*OUT_W)'($signed({1'b0, a}));
    prod = se * ae;
    prod = prod >>> (OUT_W-1);
    return prod[OUT_W-1:0];
  endfunction

  logic [PHASE_W-1:0]      phase;
  logic [1:0]              act_mode;
  logic [PHASE_W-1:0]      act_duty;
  logic [OUT_W-2:0]        act_amp;
  logic                    acc_wrap;

  phase_acc #(
    .PHASE_W(PHASE_W),
    .AMP_W  (OUT_W-1)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .mode    (mode),
    .fcw     (fcw),
    .duty    (duty),
    .amp     (amp),
    .phase   (phase),
    .act_mode(act_mode),
    .act_duty(act_duty),
    .act_amp (act_amp),
    .wrap    (acc_wrap)
  );

  logic [OUT_W-1:0]        top;
  logic [OUT_W-1:0]        t;
  logic                    msb;
  logic signed [OUT_W-1:0] raw;

  logic signed [OUT_W-1:0] raw_p1_d, raw_p1_q;
  logic [OUT_W-2:0]        amp_p1_d, amp_p1_q;
  logic                    wrap_p1_d, wrap_p1_q;
  logic signed [OUT_W-1:0] tone_p2_d, tone_p2_q;
  logic                    wrap_p2_d, wrap_p2_q;

  // Stage 1: waveform shaping from the phase register
  always_comb begin
    top = phase[PHASE_W-1 -: OUT_W];
    msb = phase[PHASE_W-1];
    t   = phase[PHASE_W-2 -: OUT_W];
    case (tone_mode_e'(act_mode))
      MODE_SQUARE:   raw = msb ? FS_NEG : FS;
      MODE_PULSE:    raw = (phase < act_duty) ? FS : FS_NEG;
      // Offset-binary to two's complement: flipping the MSB subtracts 2^(OUT_W-1).
      MODE_SAW:      raw = $signed({~top[OUT_W-1], top[OUT_W-2:0]});
      MODE_TRIANGLE: raw = msb ? (FS - $signed(t))
                               : $signed({~t[OUT_W-1], t[OUT_W-2:0]});
      default:       raw = FS;
    endcase
    raw_p1_d  = en ? sat_sym(raw) : '0;
    amp_p1_d  = en ? act_amp : '0;
    wrap_p1_d = en & acc_wrap;
  end

  // Stage 2: amplitude scaling
  always_comb begin
    tone_p2_d = en ? scale(raw_p1_q, amp_p1_q) : '0;
    wrap_p2_d = en & wrap_p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_p1_q  <= '0;
      amp_p1_q  <= '0;
      wrap_p1_q <= 1'b0;
      tone_p2_q <= '0;
      wrap_p2_q <= 1'b0;
    end else begin
      raw_p1_q  <= raw_p1_d;
      amp_p1_q  <= amp_p1_d;
      wrap_p1_q <= wrap_p1_d;
      tone_p2_q <= tone_p2_d;
      wrap_p2_q <= wrap_p2_d;
    end
  end

  assign tone = tone_p2_q;
  assign wrap = wrap_p2_q;

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen at OUT_W=8, PHASE_W=10.
module tb_tone_gen;

  localparam int OUT_W   = 8;
  localparam int PHASE_W = 10;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    load;
  logic [1:0]              mode;
  logic [PHASE_W-1:0]      fcw;
  logic [PHASE_W-1:0]      duty;
  logic [OUT_W-2:0]        amp;
  logic signed [OUT_W-1:0] tone;
  logic                    wrap;

  tone_gen #(.OUT_W(OUT_W), .PHASE_W(PHASE_W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .load(load),
    .mode(mode),
    .fcw (fcw),
    .duty(duty),
    .amp (amp),
    .tone(tone),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                      cyc;
    logic signed [OUT_W-1:0] tone;
    logic                    wrap;
    string                   name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_run  = 0;
  int   n_fail = 0;
  logic probe  = 1'b0;

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  // Monitor: pops expected samples when their cycle arrives; also checks
  // the asynchronous reset response when probed between clock edges.
  initial begin
    forever begin
      @(negedge clk or posedge probe);
      if (probe) begin
        check("rst_async_tone", tone, 0);
        check("rst_async_wrap", {31'd0, wrap}, 0);
      end else begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          mon_e = sb.pop_front();
          if (mon_e.cyc < cyc) begin
            check({mon_e.name, "_late"}, mon_e.cyc, cyc);
          end else begin
            check({mon_e.name, "_tone"}, tone, mon_e.tone);
            check({mon_e.name, "_wrap"}, {31'd0, wrap}, {31'd0, mon_e.wrap});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic signed [OUT_W-1:0] t,
                           input logic w, input string nm);
    exp_t e;
    e.cyc  = c;
    e.tone = t;
    e.wrap = w;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_wave(input int base, input logic signed [OUT_W-1:0] p0,
                             input logic signed [OUT_W-1:0] p1,
                             input logic signed [OUT_W-1:0] p2,
                             input logic signed [OUT_W-1:0] p3,
                             input logic wraps, input int n, input string nm);
    logic signed [OUT_W-1:0] pat [4];
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    for (int k = 0; k < n; k++)
      expect_at(base + 1 + k, pat[k % 4], wraps && k > 0 && (k % 4 == 0), nm);
  endtask

  // Load parameters while idle, then enable and check n samples.
  task automatic run_wave(input logic [1:0] m, input logic [PHASE_W-1:0] d,
                          input logic [OUT_W-2:0] a, input logic [PHASE_W-1:0] f,
                          input logic signed [OUT_W-1:0] p0,
                          input logic signed [OUT_W-1:0] p1,
                          input logic signed [OUT_W-1:0] p2,
                          input logic signed [OUT_W-1:0] p3,
                          input logic wraps, input int n, input string nm);
    en = 1'b0; load = 1'b1; mode = m; duty = d; amp = a; fcw = f;
    step();
    load = 1'b0;
    step();
    step();
    en = 1'b1;
    step();
    expect_wave(cyc, p0, p1, p2, p3, wraps, n, nm);
    repeat (n) step();
  endtask

  // Retune from fcw=256 to fcw=128; load_at=1 loads at phase 512,
  // load_at=2 loads in the wrap cycle (phase 768). Both give the same output.
  task automatic retune(input int load_at, input string nm);
    logic signed [OUT_W-1:0] et [13];
    logic                    ew [13];
    int                      base;
    et = '{126, 126, -127, -127, 126, 126, 126, 126, -127, -127, -127, -127, 126};
    ew = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    en = 1'b0; load = 1'b1; mode = 2'd0; duty = '0; amp = 7'd127; fcw = 10'd256;
    step();
    load = 1'b0;
    step();
    step();
    en = 1'b1;
    step();
    base = cyc;
    for (int k = 0; k < 13; k++) expect_at(base + 1 + k, et[k], ew[k], nm);
    repeat (load_at) step();
    load = 1'b1; fcw = 10'd128;
    step();
    load = 1'b0;
    repeat (12 - load_at) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0;
    fcw = '0; duty = '0; amp = '0;
    for (int i = 1; i <= 3; i++) expect_at(i, 0, 1'b0, "reset");
    repeat (3) step();
    rst = 1'b0;

    run_wave(2'd0, 10'd0,    7'd127, 10'd256, 126, 126, -127, -127, 1'b1, 12, "square");
    run_wave(2'd1, 10'd256,  7'd127, 10'd256, 126, -127, -127, -127, 1'b1, 8, "pulse");
    run_wave(2'd1, 10'd0,    7'd127, 10'd256, -127, -127, -127, -127, 1'b1, 8, "pulse_d0");
    run_wave(2'd1, 10'd1023, 7'd127, 10'd256, 126, 126, 126, 126, 1'b1, 8, "pulse_dmax");
    run_wave(2'd2, 10'd0,    7'd127, 10'd256, -127, -64, 0, 63, 1'b1, 8, "saw");
    run_wave(2'd3, 10'd0,    7'd127, 10'd256, -127, 0, 126, -1, 1'b1, 8, "tri");
    for (int m = 0; m < 4; m++)
      run_wave(2'(m), 10'd256, 7'd0, 10'd256, 0, 0, 0, 0, 1'b1, 8, "amp0");

    retune(1, "retune");
    retune(2, "retune_wrap");

    // Enable drop mid-period, then restart from phase 0.
    run_wave(2'd0, 10'd0, 7'd127, 10'd256, 126, 126, -127, -127, 1'b1, 6, "pre_drop");
    en = 1'b0;
    c = cyc;
    for (int i = 2; i <= 4; i++) expect_at(c + i, 0, 1'b0, "en_drop");
    repeat (4) step();
    en = 1'b1;
    step();
    expect_wave(cyc, 126, 126, -127, -127, 1'b1, 8, "reraise");
    repeat (8) step();

    // DC: fcw=0 never wraps.
    run_wave(2'd0, 10'd0, 7'd127, 10'd0, 126, 126, 126, 126, 1'b0, 64, "dc");

    // Asynchronous reset mid-period with a pending shadow load.
    run_wave(2'd0, 10'd0, 7'd127, 10'd256, 126, 126, -127, -127, 1'b1, 5, "pre_rst");
    load = 1'b1; mode = 2'd2; fcw = 10'd128; amp = 7'd127;
    step();
    load = 1'b0;
    #1 rst = 1'b1;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    c = cyc;
    for (int i = 1; i <= 42; i++) expect_at(c + i, 0, 1'b0, "post_rst");
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (18) step();

    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
